// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry constants and FSM state type for the data cache.
// Geometry: 8 direct-mapped blocks of 4 bytes, 8-bit byte address split as
// tag[7:5] / index[4:2] / offset[1:0].
package dcache_pkg;

    localparam int unsigned TAG_W    = 3;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned BLOCKS   = 8;
    localparam int unsigned BLOCK_W  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_store.sv
// dcache_store: valid/dirty/tag/data arrays of the data cache.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (clears valid/dirty only)
//   i_index             block selected for both read and write
//   i_byte_we/_off/_data  byte store into the selected block, marks it dirty
//   i_fill_we/_tag/_data  whole-block install, marks it valid and clean
//   o_valid/o_dirty/o_tag/o_data  combinational view of the selected block
module dcache_store
    import dcache_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic                i_byte_we,
    input  logic [OFFSET_W-1:0] i_byte_off,
    input  logic [7:0]          i_byte_data,
    input  logic                i_fill_we,
    input  logic [TAG_W-1:0]    i_fill_tag,
    input  logic [BLOCK_W-1:0]  i_fill_data,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [BLOCK_W-1:0]  o_data
);

    logic [BLOCKS-1:0]  r_valid;
    logic [BLOCKS-1:0]  r_dirty;
    logic [TAG_W-1:0]   r_tag  [BLOCKS];
    logic [BLOCK_W-1:0] r_data [BLOCKS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_byte_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tags and data are not reset; a reset only has to block any in-flight install.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (i_fill_we) begin
                r_tag[i_index]  <= i_fill_tag;
                r_data[i_index] <= i_fill_data;
            end else if (i_byte_we) begin
                r_data[i_index][{i_byte_off, 3'b000} +: 8] <= i_byte_data;
            end
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate byte cache for an 8-bit CPU.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_read, i_write, i_address, i_writedata   CPU request, held until o_busywait low
//   o_readdata, o_busywait         CPU load data and stall
//   o_mem_read, o_mem_write, o_mem_address, o_mem_writedata   block memory request
//   i_mem_readdata, i_mem_busywait                             block memory response
module dcache
    import dcache_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_read,
    input  logic               i_write,
    input  logic [7:0]         i_address,
    input  logic [7:0]         i_writedata,
    output logic [7:0]         o_readdata,
    output logic               o_busywait,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [5:0]         o_mem_address,
    output logic [BLOCK_W-1:0] o_mem_writedata,
    input  logic [BLOCK_W-1:0] i_mem_readdata,
    input  logic               i_mem_busywait
);

    state_e r_state;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_valid;
    logic                w_dirty;
    logic [TAG_W-1:0]    w_blk_tag;
    logic [BLOCK_W-1:0]  w_blk_data;
    logic                w_hit;
    logic                w_req;
    logic                w_byte_we;
    logic                w_fill_we;

    assign w_tag    = i_address[7:5];
    assign w_index  = i_address[4:2];
    assign w_offset = i_address[1:0];
    assign w_req    = i_read | i_write;
    assign w_hit    = w_valid && (w_blk_tag == w_tag);

    // A write with READ also high is still a write; stores only commit from IDLE.
    assign w_byte_we = (r_state == IDLE) && i_write && w_hit;
    assign w_fill_we = (r_state == FETCH) && !i_mem_busywait;

    dcache_store u_store (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_index     (w_index),
        .i_byte_we   (w_byte_we),
        .i_byte_off  (w_offset),
        .i_byte_data (i_writedata),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (i_mem_readdata),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_blk_tag),
        .o_data      (w_blk_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        r_state <= (w_valid && w_dirty) ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: if (!i_mem_busywait) r_state <= FETCH;
                FETCH:     if (!i_mem_busywait) r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode straight from the state register, so they are
    // glitch-free and stable for the whole request.
    always_comb begin
        o_readdata      = '0;
        o_busywait      = 1'b0;
        o_mem_read      = (r_state == FETCH);
        o_mem_write     = (r_state == WRITEBACK);
        o_mem_address   = i_address[7:2];
        o_mem_writedata = w_blk_data;
        if (r_state == WRITEBACK) begin
            o_mem_address = {w_blk_tag, w_index};
        end
        if (r_state != IDLE) begin
            o_busywait = 1'b1;
        end else if (w_req && !w_hit) begin
            o_busywait = 1'b1;
        end
        if ((r_state == IDLE) && w_hit) begin
            o_readdata = w_blk_data[{w_offset, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache with a behavioural block memory
// that completes each request after MEM_LAT cycles.
module tb_dcache;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_read          (read),
        .i_write         (write),
        .i_address       (address),
        .i_writedata     (writedata),
        .o_readdata      (readdata),
        .o_busywait      (busywait),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_mem_address   (mem_address),
        .o_mem_writedata (mem_writedata),
        .i_mem_readdata  (mem_readdata),
        .i_mem_busywait  (mem_busywait)
    );

    // Block memory model
    logic [31:0] mem [64];
    int          mcnt = 0;
    logic        mreq;

    assign mreq         = mem_read | mem_write;
    assign mem_busywait = mreq && (mcnt < MEM_LAT - 1);
    assign mem_readdata = mem[mem_address];

    always @(posedge clk) begin
        if (!mreq) begin
            mcnt <= 0;
        end else if (mem_busywait) begin
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
            if (mem_write) mem[mem_address] <= mem_writedata;
        end
    end

    // Memory-port monitor
    bit          mon_rd, mon_wr, mon_both, mon_wb_first;
    logic [5:0]  mon_rd_addr, mon_wr_addr;
    logic [31:0] mon_wr_data;

    always @(negedge clk) begin
        #2;
        if (mem_read && mem_write) mon_both = 1'b1;
        if (mem_write && !mon_wr) begin
            mon_wr      = 1'b1;
            mon_wr_addr = mem_address;
            mon_wr_data = mem_writedata;
        end
        if (mem_read && !mon_rd) begin
            mon_rd       = 1'b1;
            mon_rd_addr  = mem_address;
            mon_wb_first = mon_wr;
        end
    end

    task automatic mon_clear();
        mon_rd = 0; mon_wr = 0; mon_both = 0; mon_wb_first = 0;
        mon_rd_addr = '0; mon_wr_addr = '0; mon_wr_data = '0;
    endtask

    // Drives one CPU request until it completes; reports stall cycles and load data.
    task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                          output int stalls, output bit first_busy,
                          output logic [7:0] rdata);
        @(negedge clk);
        read      = !wr;
        write     = wr;
        address   = addr;
        writedata = wdata;
        #1;
        first_busy = busywait;
        stalls     = 0;
        while (busywait && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = readdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (busywait !== 1'b0) begin
            n_fail++; $display("FAIL reset_busywait: got %b expected 0", busywait);
        end
        n_tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_req: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
        end
        n_tests++;
        if (readdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_readdata: got %h expected 00", readdata);
        end
    endtask

    task automatic test_clean_miss();
        int st; bit fb; logic [7:0] rd;
        mon_clear();
        access(1'b0, 8'h00, 8'h00, st, fb, rd);
        n_tests++;
        if (fb !== 1'b1) begin
            n_fail++; $display("FAIL miss_busy_same_cycle: got %b expected 1", fb);
        end
        n_tests++;
        if (st != 1 + MEM_LAT) begin
            n_fail++; $display("FAIL clean_miss_stalls: got %0d expected %0d", st, 1 + MEM_LAT);
        end
        n_tests++;
        if (!mon_rd || mon_rd_addr !== 6'h00 || mon_wr) begin
            n_fail++; $display("FAIL clean_miss_mem: got rd=%b addr=%h wr=%b expected 1 00 0",
                               mon_rd, mon_rd_addr, mon_wr);
        end
        n_tests++;
        if (rd !== 8'h11) begin
            n_fail++; $display("FAIL clean_miss_data: got %h expected 11", rd);
        end
    endtask

    task automatic test_read_hit();
        int st; bit fb; logic [7:0] rd;
        mon_clear();
        access(1'b0, 8'h03, 8'h00, st, fb, rd);
        n_tests++;
        if (st != 0 || rd !== 8'h44 || mon_rd || mon_wr) begin
            n_fail++; $display("FAIL read_hit: got stalls=%0d data=%h rd=%b wr=%b expected 0 44 0 0",
                               st, rd, mon_rd, mon_wr);
        end
    endtask

    task automatic test_write_hit();
        int st; bit fb; logic [7:0] rd;
        mon_clear();
        access(1'b1, 8'h01, 8'hAB, st, fb, rd);
        n_tests++;
        if (st != 0 || mon_rd || mon_wr) begin
            n_fail++; $display("FAIL write_hit_stall: got stalls=%0d rd=%b wr=%b expected 0 0 0",
                               st, mon_rd, mon_wr);
        end
        access(1'b0, 8'h01, 8'h00, st, fb, rd);
        n_tests++;
        if (rd !== 8'hAB || st != 0) begin
            n_fail++; $display("FAIL write_hit_readback: got %h stalls=%0d expected ab 0", rd, st);
        end
    endtask

    task automatic test_dirty_miss();
        int st; bit fb; logic [7:0] rd;
        mon_clear();
        access(1'b0, 8'h20, 8'h00, st, fb, rd);
        n_tests++;
        if (st != 1 + 2 * MEM_LAT) begin
            n_fail++; $display("FAIL dirty_miss_stalls: got %0d expected %0d", st, 1 + 2 * MEM_LAT);
        end
        n_tests++;
        if (!mon_wr || mon_wr_addr !== 6'h00 || mon_wr_data !== 32'h4433AB11) begin
            n_fail++; $display("FAIL dirty_miss_wb: got wr=%b addr=%h data=%h expected 1 00 4433ab11",
                               mon_wr, mon_wr_addr, mon_wr_data);
        end
        n_tests++;
        if (!mon_rd || mon_rd_addr !== 6'h08 || !mon_wb_first) begin
            n_fail++; $display("FAIL dirty_miss_fetch: got rd=%b addr=%h wb_first=%b expected 1 08 1",
                               mon_rd, mon_rd_addr, mon_wb_first);
        end
        n_tests++;
        if (mon_both) begin
            n_fail++; $display("FAIL dirty_miss_exclusive: got both_high=1 expected 0");
        end
        n_tests++;
        if (rd !== 8'h55) begin
            n_fail++; $display("FAIL dirty_miss_data: got %h expected 55", rd);
        end
        n_tests++;
        if (mem[0] !== 32'h4433AB11) begin
            n_fail++; $display("FAIL dirty_miss_memory: got %h expected 4433ab11", mem[0]);
        end
    endtask

    task automatic test_write_miss();
        int st; bit fb; logic [7:0] rd;
        mon_clear();
        access(1'b1, 8'h9E, 8'h5A, st, fb, rd);
        n_tests++;
        if (st != 1 + MEM_LAT || !mon_rd || mon_rd_addr !== 6'h27 || mon_wr) begin
            n_fail++; $display("FAIL write_miss_fetch: got stalls=%0d rd=%b addr=%h wr=%b expected %0d 1 27 0",
                               st, mon_rd, mon_rd_addr, mon_wr, 1 + MEM_LAT);
        end
        access(1'b0, 8'h9E, 8'h00, st, fb, rd);
        n_tests++;
        if (rd !== 8'h5A || st != 0) begin
            n_fail++; $display("FAIL write_miss_byte2: got %h stalls=%0d expected 5a 0", rd, st);
        end
        access(1'b0, 8'h9C, 8'h00, st, fb, rd);
        n_tests++;
        if (rd !== 8'hAA) begin
            n_fail++; $display("FAIL write_miss_byte0: got %h expected aa", rd);
        end
        // Evicting the block must write it back, proving it was left dirty.
        mon_clear();
        access(1'b0, 8'hFC, 8'h00, st, fb, rd);
        n_tests++;
        if (!mon_wr || mon_wr_addr !== 6'h27 || mon_wr_data !== 32'hDD5ABBAA) begin
            n_fail++; $display("FAIL write_miss_dirty_wb: got wr=%b addr=%h data=%h expected 1 27 dd5abbaa",
                               mon_wr, mon_wr_addr, mon_wr_data);
        end
        n_tests++;
        if (rd !== 8'h01 || mon_rd_addr !== 6'h3F) begin
            n_fail++; $display("FAIL evict_refill: got data=%h addr=%h expected 01 3f", rd, mon_rd_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int st; bit fb; logic [7:0] rd;
        int k;
        @(negedge clk);
        read    = 1'b1;
        address = 8'h40;
        #1;
        k = 0;
        while (!mem_read && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL midfetch_reach_fetch: got mem_read=%b expected 1", mem_read);
        end
        reset = 1'b1;
        read  = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || busywait !== 1'b0) begin
            n_fail++; $display("FAIL midfetch_reset_idle: got rd=%b wr=%b busy=%b expected 0 0 0",
                               mem_read, mem_write, busywait);
        end
        @(negedge clk);
        reset = 1'b0;
        mon_clear();
        access(1'b0, 8'h20, 8'h00, st, fb, rd);
        n_tests++;
        if (!fb || st != 1 + MEM_LAT || mon_wr || mon_rd_addr !== 6'h08) begin
            n_fail++; $display("FAIL midfetch_refetch: got busy=%b stalls=%0d wr=%b addr=%h expected 1 %0d 0 08",
                               fb, st, mon_wr, mon_rd_addr, 1 + MEM_LAT);
        end
        n_tests++;
        if (rd !== 8'h55) begin
            n_fail++; $display("FAIL midfetch_data: got %h expected 55", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h00] = 32'h44332211;
        mem[6'h08] = 32'h88776655;
        mem[6'h27] = 32'hDDCCBBAA;
        mem[6'h3F] = 32'h04030201;
        mon_clear();
        test_reset();
        test_clean_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_write_miss();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
